// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte-stream input and instruction-memory write side of the loader
interface imem_loader_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 20
);
  logic               in_valid;
  logic [7:0]         in_data;
  logic               in_ready;
  logic               imem_we;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_wdata;
  logic               cpu_hold;
  logic               done;
  logic               err;
  logic [7:0]         count_loaded;

  modport master (
    output in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, err, count_loaded
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, err, count_loaded
  );
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - assembles a framed byte stream into 20-bit words and writes imem from address 0
module imem_loader #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 20
) (
  input  logic          clkwire,
  input  logic          rst,
  imem_loader_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_B0, S_B1, S_B2, S_WRITE, S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [7:0]         remaining_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [7:0]         lo_q, mid_q;
  logic [INSTR_W-1:0] wdata_q;
  logic               hold_q;
  logic               err_q;
  logic [7:0]         count_q;
  logic               xfer;

  assign xfer = bus.in_valid && bus.in_ready;

  always_ff @(posedge clkwire) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (xfer && bus.in_data != 8'd0) state_d = S_B0;
      S_B0:    if (xfer) state_d = S_B1;
      S_B1:    if (xfer) state_d = S_B2;
      S_B2:    if (xfer) state_d = S_WRITE;
      S_WRITE: state_d = (remaining_q == 8'd1) ? S_DONE : S_B0;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready = 1'b0;
    bus.imem_we  = 1'b0;
    bus.done     = 1'b0;
    case (state_q)
      S_IDLE, S_B0, S_B1, S_B2: bus.in_ready = 1'b1;
      S_WRITE:                  bus.imem_we  = 1'b1;
      S_DONE:                   bus.done     = 1'b1;
      default:                  bus.in_ready = 1'b0;
    endcase
  end

  // The output word is only replaced on the third byte, so imem_wdata stays stable between writes.
  always_ff @(posedge clkwire) begin
    if (rst) begin
      remaining_q <= 8'd0;
      addr_q      <= '0;
      lo_q        <= 8'd0;
      mid_q       <= 8'd0;
      wdata_q     <= '0;
      hold_q      <= 1'b0;
      err_q       <= 1'b0;
      count_q     <= 8'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (xfer && bus.in_data != 8'd0) begin
            remaining_q <= bus.in_data;
            addr_q      <= '0;
            err_q       <= 1'b0;
            count_q     <= 8'd0;
            hold_q      <= 1'b1;
          end
        end
        S_B0: if (xfer) lo_q <= bus.in_data;
        S_B1: if (xfer) mid_q <= bus.in_data;
        S_B2: begin
          if (xfer) begin
            wdata_q <= {bus.in_data[3:0], mid_q, lo_q};
            if (bus.in_data[7:4] != 4'd0) err_q <= 1'b1;
          end
        end
        S_WRITE: begin
          addr_q      <= addr_q + 1'b1;
          remaining_q <= remaining_q - 8'd1;
          count_q     <= count_q + 8'd1;
          if (remaining_q == 8'd1) hold_q <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.imem_addr    = addr_q;
  assign bus.imem_wdata   = wdata_q;
  assign bus.cpu_hold     = hold_q;
  assign bus.err          = err_q;
  assign bus.count_loaded = count_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed checks of the imem byte-stream loader
module tb_imem_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   wr_addr[$];
  int   wr_data[$];
  int   n_done = 0;

  imem_loader_if #(.ADDR_W(8), .INSTR_W(20)) bus ();

  imem_loader #(.ADDR_W(8), .INSTR_W(20)) dut (
    .clkwire (clk),
    .rst     (rst),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Write/done log and the in_ready decode rule, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.imem_we) begin
        wr_addr.push_back(int'(bus.imem_addr));
        wr_data.push_back(int'(bus.imem_wdata));
      end
      if (bus.done) n_done++;
      check("in_ready_decode", {31'd0, bus.in_ready}, {31'd0, !(bus.imem_we || bus.done)});
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    tick(n);
  endtask

  // Presents a byte and returns #1 after the edge that transferred it; in_valid is left high.
  task automatic send_byte(input logic [7:0] b);
    int waited;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    waited = 0;
    while (!bus.in_ready && waited < 16) begin
      tick(1);
      waited++;
    end
    if (!bus.in_ready) check("in_ready_timeout", 32'd0, 32'd1);
    tick(1);
  endtask

  initial begin
    int base;
    int dbase;
    logic [7:0] b;
    logic [7:0] nb;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h05;

    // Reset with in_valid high
    tick(2);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_we", {31'd0, bus.imem_we}, 32'd0);
    check("rst_addr", {24'd0, bus.imem_addr}, 32'd0);
    check("rst_wdata", {12'd0, bus.imem_wdata}, 32'd0);
    check("rst_hold", {31'd0, bus.cpu_hold}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_err", {31'd0, bus.err}, 32'd0);
    check("rst_count", {24'd0, bus.count_loaded}, 32'd0);
    tick(2);
    check("rst_no_write", wr_addr.size(), 32'd0);

    // Single instruction, in_valid held high
    send_byte(8'h01);
    check("s1_hold_rise", {31'd0, bus.cpu_hold}, 32'd1);
    send_byte(8'h20);
    send_byte(8'h00);
    send_byte(8'h04);
    bus.in_valid = 1'b0;
    check("s1_we", {31'd0, bus.imem_we}, 32'd1);
    check("s1_addr", {24'd0, bus.imem_addr}, 32'h00);
    check("s1_wdata", {12'd0, bus.imem_wdata}, 32'h40020);
    check("s1_hold_write", {31'd0, bus.cpu_hold}, 32'd1);
    tick(1);
    check("s1_done", {31'd0, bus.done}, 32'd1);
    check("s1_hold_fall", {31'd0, bus.cpu_hold}, 32'd0);
    check("s1_count", {24'd0, bus.count_loaded}, 32'd1);
    check("s1_we_low", {31'd0, bus.imem_we}, 32'd0);
    tick(1);
    check("s1_done_pulse", {31'd0, bus.done}, 32'd0);
    check("s1_nwrites", wr_addr.size(), 32'd1);

    // Two instructions with 3-cycle gaps between bytes
    base = wr_addr.size();
    send_byte(8'h02); idle(3);
    send_byte(8'h20); idle(3);
    send_byte(8'h00); idle(3);
    send_byte(8'h04); idle(3);
    send_byte(8'h00); idle(3);
    send_byte(8'h02); idle(3);
    send_byte(8'h03); idle(3);
    check("g2_nwrites", wr_addr.size() - base, 32'd2);
    if (wr_addr.size() - base == 2) begin
      check("g2_addr0", wr_addr[base], 32'h00);
      check("g2_data0", wr_data[base], 32'h40020);
      check("g2_addr1", wr_addr[base+1], 32'h01);
      check("g2_data1", wr_data[base+1], 32'h30200);
    end
    check("g2_err", {31'd0, bus.err}, 32'd0);
    check("g2_count", {24'd0, bus.count_loaded}, 32'd2);
    check("g2_hold", {31'd0, bus.cpu_hold}, 32'd0);

    // Format error on the top nibble of byte 2
    base = wr_addr.size();
    send_byte(8'h01);
    send_byte(8'hFF);
    send_byte(8'hFF);
    send_byte(8'hF5);
    bus.in_valid = 1'b0;
    check("fe_we", {31'd0, bus.imem_we}, 32'd1);
    check("fe_wdata", {12'd0, bus.imem_wdata}, 32'h5FFFF);
    tick(1);
    check("fe_err_after", {31'd0, bus.err}, 32'd1);
    tick(1);
    check("fe_wdata_held", {12'd0, bus.imem_wdata}, 32'h5FFFF);
    check("fe_nwrites", wr_addr.size() - base, 32'd1);

    // Zero header is discarded
    send_byte(8'h00);
    bus.in_valid = 1'b0;
    check("z_hold", {31'd0, bus.cpu_hold}, 32'd0);
    check("z_err_kept", {31'd0, bus.err}, 32'd1);
    check("z_count_kept", {24'd0, bus.count_loaded}, 32'd1);
    check("z_in_ready", {31'd0, bus.in_ready}, 32'd1);
    tick(3);
    check("z_hold_later", {31'd0, bus.cpu_hold}, 32'd0);
    check("z_nwrites", wr_addr.size() - base, 32'd1);

    // 255-instruction load, fully back-to-back
    base  = wr_addr.size();
    dbase = n_done;
    send_byte(8'hFF);
    check("big_err_clear", {31'd0, bus.err}, 32'd0);
    check("big_count_clear", {24'd0, bus.count_loaded}, 32'd0);
    check("big_addr_clear", {24'd0, bus.imem_addr}, 32'd0);
    check("big_hold", {31'd0, bus.cpu_hold}, 32'd1);
    for (int i = 0; i < 255; i++) begin
      b  = 8'(i);
      nb = ~b;
      send_byte(b);
      send_byte(nb);
      send_byte({4'h0, b[3:0]});
    end
    bus.in_valid = 1'b0;
    check("big_last_we", {31'd0, bus.imem_we}, 32'd1);
    check("big_last_addr", {24'd0, bus.imem_addr}, 32'hFE);
    tick(1);
    check("big_done", {31'd0, bus.done}, 32'd1);
    check("big_count", {24'd0, bus.count_loaded}, 32'd255);
    check("big_addr_next", {24'd0, bus.imem_addr}, 32'hFF);
    check("big_hold_fall", {31'd0, bus.cpu_hold}, 32'd0);
    tick(1);
    check("big_ndone", n_done - dbase, 32'd1);
    check("big_nwrites", wr_addr.size() - base, 32'd255);
    if (wr_addr.size() - base == 255) begin
      for (int k = 0; k < 255; k++) begin
        b  = 8'(k);
        nb = ~b;
        check($sformatf("big_addr_%0d", k), wr_addr[base+k], 32'(k));
        check($sformatf("big_data_%0d", k), wr_data[base+k], {12'd0, b[3:0], nb, b});
      end
    end
    check("big_err", {31'd0, bus.err}, 32'd0);

    // Reset in the middle of the second instruction, with a transfer on the reset edge
    base  = wr_addr.size();
    dbase = n_done;
    send_byte(8'h03);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h03);
    send_byte(8'h44);
    send_byte(8'h55);
    bus.in_data = 8'h06;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    check("mr_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("mr_hold", {31'd0, bus.cpu_hold}, 32'd0);
    check("mr_count", {24'd0, bus.count_loaded}, 32'd0);
    check("mr_addr", {24'd0, bus.imem_addr}, 32'd0);
    tick(6);
    check("mr_nwrites", wr_addr.size() - base, 32'd1);
    if (wr_addr.size() - base == 1) begin
      check("mr_data", wr_data[base], 32'h32211);
    end
    check("mr_ndone", n_done - dbase, 32'd0);
    check("mr_we", {31'd0, bus.imem_we}, 32'd0);

    // Back-to-back frames: second header accepted right after DONE
    base = wr_addr.size();
    send_byte(8'h01);
    send_byte(8'hAB);
    send_byte(8'hCD);
    send_byte(8'h0E);
    send_byte(8'h01);
    check("bb_hold", {31'd0, bus.cpu_hold}, 32'd1);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    bus.in_valid = 1'b0;
    tick(3);
    check("bb_nwrites", wr_addr.size() - base, 32'd2);
    if (wr_addr.size() - base == 2) begin
      check("bb_data0", wr_data[base], 32'hECDAB);
      check("bb_addr1", wr_addr[base+1], 32'h00);
      check("bb_data1", wr_data[base+1], 32'h30201);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Byte-stream program loader. It is the write side of the instruction memory that if_unit fetches from.
- Accepts a framed byte stream on a valid/ready handshake and assembles each group of three bytes into one 20-bit instruction.
- Writes the instructions into instruction memory at consecutive addresses starting at 0.
- Holds the pipeline (PC/fetch) while a load is in progress.

Parameters:
- ADDR_W, 8, instruction memory address width (matches 8-bit pc)
- INSTR_W, 20, instruction width; fixed at 20, other values unsupported

Ports:
- clkwire  input  1  single clock; all state changes on posedge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  in_data holds a valid byte
- in_data  input  8  stream byte (header or instruction byte)
- in_ready  output  1  loader can accept a byte this cycle
- imem_we  output  1  one-cycle instruction memory write strobe
- imem_addr  output  ADDR_W  write address
- imem_wdata  output  INSTR_W  write data
- cpu_hold  output  1  high while a load is in progress; fetch/PC must freeze
- done  output  1  one-cycle pulse on load completion
- err  output  1  sticky format error for the current session
- count_loaded  output  8  instructions written in the current/last session

Behaviour:
- Handshake:
  - A byte transfers on a posedge with in_valid=1 and in_ready=1.
  - in_ready is decoded from state: 1 in IDLE, B0, B1, B2; 0 in WRITE and DONE.
  - in_data is ignored when no transfer occurs.
- Frame format:
  - One header byte N = instruction count.
  - Followed by 3N bytes per instruction, little-endian: byte0→[7:0], byte1→[15:8], byte2[3:0]→[19:16].
- States: IDLE, B0, B1, B2, WRITE, DONE.
- IDLE:
  - Header transfer with N=0: the byte is consumed and discarded; stay in IDLE; err and count_loaded unchanged.
  - Header transfer with N≠0: remaining←N, imem_addr←0, err←0, count_loaded←0, cpu_hold←1, go to B0.
- B0 / B1: capture the byte into its field, advance to B1 / B2. No transfer → hold state.
- B2 on transfer:
  - Capture byte2[3:0], go to WRITE.
  - If byte2[7:4]≠0, set err←1; the nibble is dropped and the write still happens.
- WRITE (exactly one cycle):
  - imem_we=1, imem_addr=current address, imem_wdata=assembled word.
  - Next cycle: address+1 (wraps 255→0), remaining-1, count_loaded+1 (8-bit, wraps).
  - remaining becomes 0 → DONE, otherwise → B0.
- DONE (one cycle): done=1, cpu_hold←0, then IDLE.
- Latency:
  - imem_we asserts in the cycle after the third byte's transfer edge.
  - Minimum 4 cycles per instruction.
  - done asserts the cycle after the last write.
- cpu_hold:
  - Registered.
  - Rises the cycle after the header transfer.
  - Falls the cycle after WRITE of the last instruction, i.e. it is low during DONE.
- imem_wdata / imem_addr hold their last values when imem_we=0. Memory only samples them on imem_we.
- Reset:
  - On rst=1 at posedge: state←IDLE, imem_we←0, imem_addr←0, imem_wdata←0, cpu_hold←0, done←0, err←0, count_loaded←0, remaining←0.
  - in_ready is 1 from the first cycle after reset.
- Reset mid-frame:
  - Any partially assembled instruction is discarded and no write occurs.
  - Already-written words stay in memory.
  - rst has priority over any simultaneous transfer.
- Bytes arriving while in_ready=0 are not consumed. The sender holds them (standard valid/ready; in_valid may stay high).
- Back-to-back frames: a new header is accepted in IDLE immediately after DONE.

Test Plan:
- Reset: assert rst 2 cycles with in_valid=1 → in_ready=1 after release, all other outputs 0, no imem_we.
- Single instruction: bytes 0x01, 0x20, 0x00, 0x04 with in_valid held high → one imem_we with addr=0x00, wdata=0x40020; done one cycle later; count_loaded=1; cpu_hold high from header+1 to the WRITE cycle inclusive.
- Two instructions with gaps:
  - Stream: 0x02 | 0x20,0x00,0x04 | 0x00,0x02,0x03, with in_valid deasserted for 3 cycles between every byte.
  - Expect writes (0x00,0x40020) and (0x01,0x30200); in_ready=0 only during WRITE/DONE; err=0.
- Format error: header 0x01, bytes 0xFF,0xFF,0xF5 → write wdata=0x5FFFF, err=1 after the write, stays 1 until the next nonzero header.
- Zero header and wrap:
  - Header 0x00 → no state change, cpu_hold stays 0.
  - Header 0x00 followed by a 256-instruction load is not possible; instead load N=255, then check imem_addr of the last write = 0xFE and count_loaded=255.
- Reset mid-frame: header 0x03, one full instruction, then 2 bytes, then rst → exactly one write observed, state IDLE, cpu_hold=0, count_loaded=0.
